// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin index arbiter.
// N and IDX_W are tied to the width of the downstream 3-to-8 decoder.
package arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first requester at or after ptr,
// scanning upward modulo N.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output idx_t         pick,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  idx_t           off;

  assign dbl = {req, req};

  // Duplicating the vector lets a plain shift stand in for a rotate.
  // The descending loop leaves the lowest set bit of the rotated view in off.
  always_comb begin
    rot = dbl[ptr +: N];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = idx_t'(i);
    end
    pick = ptr + off;
    any  = |req;
  end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter with a registered grant index, a hold-time limit and a
// one-cycle timeout pulse when a grant is revoked by that limit.
module rr_index_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] req,
  input  logic         done,
  output idx_t         idx,
  output logic         valid,
  output logic         timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t st;
  idx_t       ptr;
  logic [7:0] hold_cnt;
  idx_t       pick;
  logic       any;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // Every grant exit passes through IDLE, so consecutive grants always have
  // at least one cycle of valid low. A withdrawn request counts as done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st       <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (st)
        IDLE: begin
          if (any) begin
            idx      <= pick;
            valid    <= 1'b1;
            hold_cnt <= '0;
            st       <= GRANT;
          end
        end
        GRANT: begin
          if (done || !req[idx] || hold_cnt == HOLD_LAST) begin
            valid   <= 1'b0;
            ptr     <= idx_t'(idx + 1'b1);
            st      <= IDLE;
            timeout <= !done && req[idx];
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: directed vector table, hand-written hold/reset
// sequences and randomized traffic checked against a grant-level model.
module tb_rr_index_arbiter;

  localparam int MAX_HOLD = 15;

  logic       clk;
  logic       nrst;
  logic [7:0] req;
  logic       done;
  logic [2:0] idx;
  logic       valid;
  logic       timeout;
  logic [7:0] dec;

  int tests;
  int fails;

  // Grant-level reference: who owns the bus, for how many cycles, and where
  // the next round-robin search starts.
  int m_ptr;
  int m_idx;
  int m_age;
  bit m_valid;
  bit m_to;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [2:0] idx;
    logic       valid;
    logic       timeout;
  } vec_t;

  vec_t tbl[$];

  rr_index_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .req     (req),
    .done    (done),
    .idx     (idx),
    .valid   (valid),
    .timeout (timeout)
  );

  // Stand-in for the downstream 3-to-8 decoder.
  assign dec = 8'b1 << idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    m_ptr   = 0;
    m_idx   = 0;
    m_age   = 0;
    m_valid = 0;
    m_to    = 0;
  endfunction

  function automatic void modelStep(input logic [7:0] r, input logic d);
    m_to = 0;
    if (!m_valid) begin
      for (int i = 0; i < 8; i++) begin
        if (!m_valid && r[(m_ptr + i) % 8]) begin
          m_idx   = (m_ptr + i) % 8;
          m_valid = 1;
          m_age   = 1;
        end
      end
    end else if (d || !r[m_idx]) begin
      m_valid = 0;
      m_ptr   = (m_idx + 1) % 8;
    end else if (m_age == MAX_HOLD) begin
      m_valid = 0;
      m_ptr   = (m_idx + 1) % 8;
      m_to    = 1;
    end else begin
      m_age = m_age + 1;
    end
  endfunction

  function automatic void addVec(input logic [7:0] r, input logic d,
                                 input logic [2:0] ei, input logic ev, input logic et);
    vec_t v;
    v.req = r; v.done = d; v.idx = ei; v.valid = ev; v.timeout = et;
    tbl.push_back(v);
  endfunction

  task automatic applyStimulus(input logic [7:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    @(posedge clk);
    modelStep(r, d);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] ei,
                             input logic ev, input logic et);
    logic [7:0] gated;
    bit         dec_ok;
    tests++;
    if ({idx, valid, timeout} !== {ei, ev, et}) begin
      fails++;
      $display("[TB] FAIL %s: got idx=%0d valid=%0b timeout=%0b, want idx=%0d valid=%0b timeout=%0b",
               name, idx, valid, timeout, ei, ev, et);
    end
    gated  = dec & {8{valid}};
    dec_ok = valid ? ($onehot(gated) && ((gated & ~req) == 8'h00)) : (gated == 8'h00);
    tests++;
    if (!dec_ok) begin
      fails++;
      $display("[TB] FAIL %s decoder: got grant lines=%02h with req=%02h, want one-hot within req",
               name, gated, req);
    end
  endtask

  task automatic doReset();
    nrst = 1'b0;
    req  = 8'h00;
    done = 1'b0;
    modelReset();
    #12;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    logic [7:0] cur_req;
    logic       cur_done;
    tests = 0;
    fails = 0;
    nrst  = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    modelReset();

    doReset();
    #1;
    checkOutput("reset", 3'd0, 1'b0, 1'b0);

    // Two requesters alternate: 0,7,0,7 with a valid gap after each done.
    addVec(8'h81, 0, 3'd0, 1, 0); addVec(8'h81, 1, 3'd0, 0, 0);
    addVec(8'h81, 0, 3'd7, 1, 0); addVec(8'h81, 1, 3'd7, 0, 0);
    addVec(8'h81, 0, 3'd0, 1, 0); addVec(8'h81, 1, 3'd0, 0, 0);
    addVec(8'h81, 0, 3'd7, 1, 0); addVec(8'h81, 1, 3'd7, 0, 0);
    // Single requester: three grant cycles, done, one idle, re-grant.
    addVec(8'h01, 0, 3'd0, 1, 0); addVec(8'h01, 0, 3'd0, 1, 0);
    addVec(8'h01, 0, 3'd0, 1, 0); addVec(8'h01, 1, 3'd0, 0, 0);
    addVec(8'h01, 0, 3'd0, 1, 0); addVec(8'h01, 1, 3'd0, 0, 0);
    // Everybody requesting from ptr=1: 1..7 then wrap to 0.
    for (int k = 1; k <= 8; k++) begin
      addVec(8'hFF, 0, 3'(k % 8), 1, 0);
      addVec(8'hFF, 1, 3'(k % 8), 0, 0);
    end
    // Withdrawal of channel 3 releases without timeout and moves ptr to 4.
    addVec(8'h08, 0, 3'd3, 1, 0); addVec(8'h08, 0, 3'd3, 1, 0);
    addVec(8'h00, 0, 3'd3, 0, 0); addVec(8'h00, 0, 3'd3, 0, 0);
    addVec(8'h18, 0, 3'd4, 1, 0); addVec(8'h18, 1, 3'd4, 0, 0);
    // done while idle is ignored.
    addVec(8'h00, 1, 3'd4, 0, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].req, tbl[i].done);
      checkOutput($sformatf("table[%0d]", i), tbl[i].idx, tbl[i].valid, tbl[i].timeout);
    end

    // Hold limit with ptr=5: channel 2 holds 15 cycles, then timeout pulse.
    for (int c = 1; c <= MAX_HOLD; c++) begin
      applyStimulus(8'h04, 0);
      checkOutput($sformatf("hold cycle %0d", c), 3'd2, 1'b1, 1'b0);
    end
    applyStimulus(8'h04, 0);
    checkOutput("timeout pulse", 3'd2, 1'b0, 1'b1);
    applyStimulus(8'h04, 0);
    checkOutput("regrant after timeout", 3'd2, 1'b1, 1'b0);
    applyStimulus(8'h04, 1);
    checkOutput("release after regrant", 3'd2, 1'b0, 1'b0);

    // done in the last hold cycle wins over the limit.
    for (int c = 1; c <= MAX_HOLD; c++) begin
      applyStimulus(8'h04, 0);
      checkOutput($sformatf("limit hold %0d", c), 3'd2, 1'b1, 1'b0);
    end
    applyStimulus(8'h04, 1);
    checkOutput("done at limit", 3'd2, 1'b0, 1'b0);
    applyStimulus(8'h00, 0);
    checkOutput("idle after limit", 3'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant to channel 5.
    applyStimulus(8'h20, 0);
    checkOutput("grant before reset", 3'd5, 1'b1, 1'b0);
    #2;
    nrst = 1'b0;
    modelReset();
    #1;
    checkOutput("async reset", 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    modelStep(req, done);
    #1;
    checkOutput("grant after reset", 3'd5, 1'b1, 1'b0);
    applyStimulus(8'h20, 1);
    checkOutput("release after reset", 3'd5, 1'b0, 1'b0);

    // Random traffic in three phases of increasing done probability.
    doReset();
    cur_req = 8'h00;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(9) == 0) begin
          cur_req = ($urandom_range(1) == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
        end
        cur_done = (ph == 0) ? 1'b0 : ($urandom_range(3 - ph) == 0);
        applyStimulus(cur_req, cur_done);
        checkOutput($sformatf("random ph%0d c%0d", ph, c), 3'(m_idx), m_valid, m_to);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
